// File: rtl/lcd_rx_pkg.sv
// Shared opcode masks, DDRAM geometry, error bit indices and address helpers for the LCD bus receiver.
package lcd_rx_pkg;

   localparam logic [7:0] CMD_CLEAR       = 8'h01;
   localparam logic [7:0] CMD_HOME_MSK    = 8'h02;
   localparam logic [7:0] CMD_ENTRY_MSK   = 8'h04;
   localparam logic [7:0] CMD_DISPLAY_MSK = 8'h08;
   localparam logic [7:0] CMD_SHIFT_MSK   = 8'h10;
   localparam logic [7:0] CMD_FUNC_MSK    = 8'h20;
   localparam logic [7:0] CMD_CGRAM_MSK   = 8'h40;
   localparam logic [7:0] CMD_DDRAM_MSK   = 8'h80;

   localparam int         LINE_LEN   = 16;
   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);
   localparam logic [6:0] LINE2_LAST = LINE2_BASE + 7'(LINE_LEN - 1);
   localparam logic [6:0] LINE_MSK   = ~7'(LINE_LEN - 1);

   localparam logic [7:0] FILL_CHAR = 8'h20;

   localparam int ERR_SHORT_PULSE = 3;
   localparam int ERR_READ_STROBE = 2;
   localparam int ERR_UNMAPPED    = 1;
   localparam int ERR_WHILE_BUSY  = 0;

   typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

   typedef enum logic [2:0] {
      OP_NOP, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISPLAY, OP_SET_ADDR
   } op_t;

   typedef struct packed {
      logic       ok;
      logic [4:0] pos;
   } ddram_pos_t;

   // Highest set bit selects the instruction; shift/function/CGRAM are accepted as no-ops.
   function automatic op_t decode_cmd(input logic [7:0] c);
      op_t op;
      if ((c & CMD_DDRAM_MSK) != 8'h00)                                       op = OP_SET_ADDR;
      else if ((c & (CMD_CGRAM_MSK | CMD_FUNC_MSK | CMD_SHIFT_MSK)) != 8'h00) op = OP_NOP;
      else if ((c & CMD_DISPLAY_MSK) != 8'h00)                                op = OP_DISPLAY;
      else if ((c & CMD_ENTRY_MSK) != 8'h00)                                  op = OP_ENTRY;
      else if ((c & CMD_HOME_MSK) != 8'h00)                                   op = OP_HOME;
      else if (c == CMD_CLEAR)                                                op = OP_CLEAR;
      else                                                                    op = OP_NOP;
      return op;
   endfunction

   function automatic ddram_pos_t ddram_pos(input logic [6:0] a);
      ddram_pos_t p;
      p.ok  = 1'b0;
      p.pos = {1'b0, a[3:0]};
      if ((a & LINE_MSK) == LINE1_BASE) begin
         p.ok = 1'b1;
      end else if ((a & LINE_MSK) == LINE2_BASE) begin
         p.ok     = 1'b1;
         p.pos[4] = 1'b1;
      end
      return p;
   endfunction

   // Cursor wraps between the ends of the two visible lines rather than through the gap.
   function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
      logic [6:0] n;
      if (inc) begin
         if (a == LINE1_LAST)      n = LINE2_BASE;
         else if (a == LINE2_LAST) n = LINE1_BASE;
         else                      n = a + 7'd1;
      end else begin
         if (a == LINE2_BASE)      n = LINE1_LAST;
         else if (a == LINE1_BASE) n = LINE2_LAST;
         else                      n = a - 7'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display RAM: one synchronous write port, one registered read port (read-before-write).
module lcd_ddram
   import lcd_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [4:0] waddr,
   input  logic [7:0] wdata,
   input  logic [4:0] raddr,
   output logic [7:0] rdata
);
   localparam int DEPTH = 2 * LINE_LEN;

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata <= '0;
      else     rdata <= mem[raddr];
   end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Snoops an HD44780-style parallel bus and mirrors the 2x16 DDRAM and display state.
// Define LCD_RX_STATS_EN to add cmd_count/data_count outputs.
module lcd_bus_receiver
   import lcd_rx_pkg::*;
#(
   parameter int MIN_E_HIGH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lcd_rs,
   input  logic        lcd_rw,
   input  logic        lcd_e,
   input  logic [7:0]  lcd_data,
   input  logic [4:0]  rd_addr,
   output logic [7:0]  rd_data,
   output logic [6:0]  cursor_addr,
   output logic        display_on,
   output logic        entry_inc,
   output logic        busy,
   output logic        cmd_valid,
   output logic        data_valid,
`ifdef LCD_RX_STATS_EN
   output logic [3:0]  err,
   output logic [15:0] cmd_count,
   output logic [15:0] data_count
`else
   output logic [3:0]  err
`endif
);
   localparam int            CW       = $clog2(MIN_E_HIGH + 2);
   localparam logic [CW-1:0] HIGH_MIN = CW'(MIN_E_HIGH);

   state_t        state, state_next;
   logic          e_q, rs_q, rw_q;
   logic [7:0]    dat_q;
   logic [CW-1:0] high_cnt;
   logic [4:0]    clr_idx;
   logic          fall, long_enough, exec;
   op_t           op;
   ddram_pos_t    wpos;
   logic          ram_we;
   logic [4:0]    ram_waddr;
   logic [7:0]    ram_wdata;

   assign busy        = (state == ST_CLEAR);
   assign fall        = e_q & ~lcd_e;
   assign long_enough = (high_cnt >= HIGH_MIN);
   assign exec        = fall & long_enough & ~rw_q & ~busy;
   assign op          = decode_cmd(dat_q);
   assign wpos        = ddram_pos(cursor_addr);

   // Bus fields follow the pin values for as long as E is high; the last sample is the one used.
   always_ff @(posedge clk) begin
      if (rst) begin
         e_q      <= 1'b0;
         high_cnt <= '0;
         rs_q     <= 1'b0;
         rw_q     <= 1'b0;
         dat_q    <= '0;
      end else begin
         e_q <= lcd_e;
         if (lcd_e) begin
            rs_q  <= lcd_rs;
            rw_q  <= lcd_rw;
            dat_q <= lcd_data;
            if (high_cnt != HIGH_MIN) high_cnt <= high_cnt + 1'b1;
         end else begin
            high_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         clr_idx <= '0;
      end else begin
         state   <= state_next;
         clr_idx <= busy ? clr_idx + 5'd1 : 5'd0;
      end
   end

   always_comb begin
      state_next = state;
      ram_we     = 1'b0;
      ram_waddr  = wpos.pos;
      ram_wdata  = dat_q;
      case (state)
         ST_IDLE: begin
            if (exec && !rs_q && op == OP_CLEAR) state_next = ST_CLEAR;
            else if (exec && rs_q && wpos.ok)    ram_we     = 1'b1;
         end
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx;
            ram_wdata = FILL_CHAR;
            if (clr_idx == 5'(2 * LINE_LEN - 1)) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (rst) ram_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cursor_addr <= LINE1_BASE;
         display_on  <= 1'b0;
         entry_inc   <= 1'b1;
         cmd_valid   <= 1'b0;
         data_valid  <= 1'b0;
         err         <= '0;
      end else begin
         cmd_valid  <= 1'b0;
         data_valid <= 1'b0;
         if (fall && !long_enough) err[ERR_SHORT_PULSE] <= 1'b1;
         if (fall && long_enough && rw_q) err[ERR_READ_STROBE] <= 1'b1;
         if (fall && long_enough && busy) err[ERR_WHILE_BUSY] <= 1'b1;
         if (exec && rs_q) begin
            data_valid  <= 1'b1;
            cursor_addr <= step_addr(cursor_addr, entry_inc);
            if (!wpos.ok) err[ERR_UNMAPPED] <= 1'b1;
         end
         if (exec && !rs_q) begin
            cmd_valid <= 1'b1;
            case (op)
               OP_SET_ADDR: cursor_addr <= dat_q[6:0];
               OP_DISPLAY:  display_on  <= dat_q[2];
               OP_ENTRY:    entry_inc   <= dat_q[1];
               OP_HOME:     cursor_addr <= LINE1_BASE;
               OP_CLEAR: begin
                  cursor_addr <= LINE1_BASE;
                  entry_inc   <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef LCD_RX_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_count  <= '0;
         data_count <= '0;
      end else begin
         if (cmd_valid)  cmd_count  <= cmd_count + 16'd1;
         if (data_valid) data_count <= data_count + 16'd1;
      end
   end
`endif

   lcd_ddram u_ddram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed scenarios plus randomized bus traffic, checked every cycle against a behavioural display model.
module tb_lcd_bus_receiver;
   localparam int MIN_E_HIGH = 2;

   logic       clk = 1'b0;
   logic       rst, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic [6:0] cursor_addr;
   logic       display_on, entry_inc, busy, cmd_valid, data_valid;
   logic [3:0] err;
`ifdef LCD_RX_STATS_EN
   logic [15:0] cmd_count, data_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   bit rnd_rd   = 1'b0;

   always #5 clk = ~clk;

   lcd_bus_receiver #(.MIN_E_HIGH(MIN_E_HIGH)) dut (
      .clk         (clk),
      .rst         (rst),
      .lcd_rs      (lcd_rs),
      .lcd_rw      (lcd_rw),
      .lcd_e       (lcd_e),
      .lcd_data    (lcd_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .cursor_addr (cursor_addr),
      .display_on  (display_on),
      .entry_inc   (entry_inc),
      .busy        (busy),
      .cmd_valid   (cmd_valid),
      .data_valid  (data_valid),
`ifdef LCD_RX_STATS_EN
      .err         (err),
      .cmd_count   (cmd_count),
      .data_count  (data_count)
`else
      .err         (err)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual 0x%0h required 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_cur, m_run, m_clr_left;
   bit         m_inc, m_disp, m_cv, m_dv, m_eprev, m_busy_before;
   logic [3:0] m_err;
   logic [7:0] m_ram [32];
   bit         m_known [32];
   logic [7:0] m_rd;
   bit         m_rd_known;
   bit         m_lrs, m_lrw;
   logic [7:0] m_ld;

   function automatic int step(input int a, input bit inc);
      if (inc) begin
         if (a == 15) return 64;
         if (a == 79) return 0;
         return (a + 1) % 128;
      end
      if (a == 64) return 15;
      if (a == 0)  return 79;
      return (a + 127) % 128;
   endfunction

   function automatic int pos_of(input int a);
      if (a < 16) return a;
      if (a >= 64 && a < 80) return a - 48;
      return -1;
   endfunction

   function automatic void model_accept(input bit bsy);
      int p;
      if (m_run < MIN_E_HIGH) begin
         m_err[3] = 1'b1;
         return;
      end
      if (m_lrw) m_err[2] = 1'b1;
      if (bsy)   m_err[0] = 1'b1;
      if (m_lrw || bsy) return;
      if (m_lrs) begin
         m_dv = 1'b1;
         p = pos_of(m_cur);
         if (p < 0) m_err[1] = 1'b1;
         else begin
            m_ram[p]   = m_ld;
            m_known[p] = 1'b1;
         end
         m_cur = step(m_cur, m_inc);
      end else begin
         m_cv = 1'b1;
         if (m_ld >= 128)     m_cur = int'(m_ld) - 128;
         else if (m_ld >= 16) m_cur = m_cur;
         else if (m_ld >= 8)  m_disp = m_ld[2];
         else if (m_ld >= 4)  m_inc = m_ld[1];
         else if (m_ld >= 2)  m_cur = 0;
         else if (m_ld == 1) begin
            m_cur = 0;
            m_inc = 1'b1;
            m_clr_left = 32;
         end
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cur = 0; m_disp = 0; m_inc = 1; m_cv = 0; m_dv = 0;
         m_err = '0; m_clr_left = 0; m_run = 0; m_eprev = 0;
         m_rd = 8'h00; m_rd_known = 1;
         foreach (m_known[i]) m_known[i] = 1'b0;
      end else begin
         m_busy_before = (m_clr_left > 0);
         m_cv = 0; m_dv = 0;
         m_rd       = m_ram[rd_addr];
         m_rd_known = m_known[rd_addr];
         if (m_clr_left > 0) begin
            m_ram[32 - m_clr_left]   = 8'h20;
            m_known[32 - m_clr_left] = 1'b1;
            m_clr_left--;
         end
         if (m_eprev && !lcd_e) model_accept(m_busy_before);
         if (lcd_e) begin
            m_run++;
            m_lrs = lcd_rs; m_lrw = lcd_rw; m_ld = lcd_data;
         end else begin
            m_run = 0;
         end
         m_eprev = lcd_e;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model cursor_addr", 32'(cursor_addr), 32'(m_cur));
         chk("model display_on",  32'(display_on),  32'(m_disp));
         chk("model entry_inc",   32'(entry_inc),   32'(m_inc));
         chk("model busy",        32'(busy),        32'(m_clr_left > 0));
         chk("model cmd_valid",   32'(cmd_valid),   32'(m_cv));
         chk("model data_valid",  32'(data_valid),  32'(m_dv));
         chk("model err",         32'(err),         32'(m_err));
         if (m_rd_known) chk("model rd_data", 32'(rd_data), 32'(m_rd));
      end
   end

   // ---------------- stimulus ----------------
   task automatic nclk();
      @(negedge clk);
      if (rnd_rd) rd_addr = 5'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) nclk();
   endtask

   task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int hi);
      nclk();
      lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
      repeat (hi) nclk();
      lcd_e = 1'b0;
      lcd_data = 8'($urandom);
   endtask

   task automatic send(input logic rs, input logic [7:0] d);
      strobe(rs, 1'b0, d, MIN_E_HIGH);
      idle(2);
   endtask

   task automatic rd_lit(input int a, input logic [7:0] exp, input string name);
      nclk();
      rd_addr = 5'(a);
      nclk();
      chk(name, 32'(rd_data), 32'(exp));
   endtask

   task automatic wait_idle(input string name);
      int i;
      i = 0;
      idle(2);
      while (busy && i < 100) begin
         nclk();
         i++;
      end
      chk(name, 32'(busy), 32'd0);
   endtask

   logic [7:0] tbl [12];
   logic [7:0] hello [5];

   initial begin
      int cnt, r, hi;
      logic rs, rw;
      logic [7:0] d;
      tbl   = '{8'h06, 8'h04, 8'h07, 8'h0C, 8'h08, 8'h02, 8'h8F, 8'hCF, 8'h4F, 8'h80, 8'hC0, 8'h10};
      hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      rst = 1; lcd_e = 0; lcd_rs = 0; lcd_rw = 0; lcd_data = 0; rd_addr = 0;

      repeat (3) @(negedge clk);
      chk_en = 1;
      chk("reset cursor_addr", 32'(cursor_addr), 32'h00);
      chk("reset display_on",  32'(display_on),  32'h0);
      chk("reset entry_inc",   32'(entry_inc),   32'h1);
      chk("reset busy",        32'(busy),        32'h0);
      chk("reset err",         32'(err),         32'h0);
      chk("reset rd_data",     32'(rd_data),     32'h00);

      // E already high while reset releases: one post-reset high cycle is a short pulse
      lcd_e = 1; lcd_rs = 1; lcd_data = 8'h99;
      nclk(); rst = 0;
      nclk(); lcd_e = 0;
      idle(2);
      chk("e high across reset err", 32'(err), 32'h8);
      chk("e high across reset cursor", 32'(cursor_addr), 32'h00);

      strobe(0, 0, 8'h01, 2);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         nclk();
         if (busy) cnt++;
      end
      chk("clear busy cycles", 32'(cnt), 32'd32);
      chk("clear cursor_addr", 32'(cursor_addr), 32'h00);
      for (int a = 0; a < 32; a++) rd_lit(a, 8'h20, "clear fill");

      send(0, 8'h06);
      send(0, 8'h0C);
      for (int i = 0; i < 5; i++) send(1, hello[i]);
      chk("hello display_on", 32'(display_on), 32'h1);
      chk("hello cursor_addr", 32'(cursor_addr), 32'h05);
      for (int i = 0; i < 5; i++) rd_lit(i, hello[i], "hello char");

      send(0, 8'h8F);
      send(1, 8'h41);
      send(1, 8'h42);
      rd_lit(15, 8'h41, "line wrap pos15");
      rd_lit(16, 8'h42, "line wrap pos16");
      chk("line wrap cursor_addr", 32'(cursor_addr), 32'h41);

      send(0, 8'h04);
      send(0, 8'h80);
      send(1, 8'h5A);
      rd_lit(0, 8'h5A, "decrement pos0");
      chk("decrement cursor_addr", 32'(cursor_addr), 32'h4F);

      strobe(0, 0, 8'h01, 2);
      idle(2);
      send(1, 8'h33);
      wait_idle("clear finishes");
      strobe(1, 0, 8'h77, 1);
      idle(2);
      strobe(1, 1, 8'h00, 2);
      idle(2);
      send(0, 8'hA0);
      send(1, 8'h55);
      chk("all errors err", 32'(err), 32'hF);
      chk("all errors cursor_addr", 32'(cursor_addr), 32'h21);
      for (int a = 0; a < 32; a++) rd_lit(a, 8'h20, "errors ram intact");

      strobe(0, 0, 8'h01, 2);
      idle(11);
      chk("mid clear busy", 32'(busy), 32'h1);
      rst = 1;
      nclk();
      chk("abort busy", 32'(busy), 32'h0);
      chk("abort cursor_addr", 32'(cursor_addr), 32'h00);
      chk("abort err", 32'(err), 32'h0);
      rst = 0;

      send(0, 8'h01);
      wait_idle("random prep clear");
      rnd_rd = 1;
      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            nclk(); rst = 1;
            nclk(); rst = 0;
         end else begin
            rs = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 7) == 0);
            d  = 8'($urandom);
            if (r < 6) begin
               rs = 0;
               d  = 8'h01;
            end else if (r < 30 && !rs) begin
               d = tbl[$urandom_range(0, 11)];
            end
            hi = $urandom_range(1, 4);
            strobe(rs, rw, d, hi);
            idle($urandom_range(0, 3));
         end
      end
      rnd_rd = 0;
      idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
      $fatal(1);
   end

endmodule
